// File: rtl/nios_debug_cmd_sequencer_if.sv
// Command, memory and monitor signals of the Nios debug command sequencer.
// slave = the sequencer itself, master = the debug host / memory side driving it.
interface nios_debug_cmd_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [37:0]       cmd_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       mon_dreg;
  logic              mon_ready;
  logic              mon_error;
  logic              err_clr;

  modport master (
    output cmd_valid, cmd_data, mem_ack, mem_rdata, err_clr,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, mon_dreg, mon_ready, mon_error
  );

  modport slave (
    input  cmd_valid, cmd_data, mem_ack, mem_rdata, err_clr,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, mon_dreg, mon_ready, mon_error
  );
endinterface

// File: rtl/nios_debug_cmd_sequencer.sv
// Buffers jdo-format debug commands and plays them onto OCI memory one word at a time.
// Optional odd-parity command check: define NIOS_DEBUG_CMD_PARITY_EN.
module nios_debug_cmd_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                       clk,
  input logic                       reset_n,
  nios_debug_cmd_sequencer_if.slave bus
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic        inc;
`ifdef NIOS_DEBUG_CMD_PARITY_EN
    logic        par_ok;
`endif
    logic [31:0] payload;
  } cmd_t;

  cmd_t              fifo_mem [CMD_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              push, pop, empty, full;
  cmd_t              cmd_in, cmd_q;
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [TW-1:0]     tmo;
  logic              acc_ok;
  logic              tmo_hit, par_err;

  assign empty         = (count == '0);
  assign full          = (count == (PW+1)'(CMD_DEPTH));
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == S_IDLE) && !empty;

  // Parity is folded to one bit at push time so only the verdict is stored.
  always_comb begin
    cmd_in         = '0;
    cmd_in.op      = bus.cmd_data[37:36];
    cmd_in.inc     = bus.cmd_data[35];
    cmd_in.payload = bus.cmd_data[31:0];
`ifdef NIOS_DEBUG_CMD_PARITY_EN
    cmd_in.par_ok  = ^bus.cmd_data;
`endif
  end

`ifdef NIOS_DEBUG_CMD_PARITY_EN
  assign par_err = (state == S_DECODE) && !cmd_q.par_ok;
`else
  logic unused_bits;
  assign unused_bits = ^bus.cmd_data[34:32];
  assign par_err     = 1'b0;
`endif

  assign tmo_hit = (state == S_ACCESS) && !bus.mem_ack && (tmo == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= cmd_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cmd_q         <= '0;
      addr          <= '0;
      tmo           <= '0;
      acc_ok        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mon_dreg  <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          cmd_q <= fifo_mem[rd_ptr];
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (par_err) state <= S_IDLE;
          else begin
            case (cmd_q.op)
              OP_SETADDR: begin
                addr  <= cmd_q.payload[ADDR_W-1:0];
                state <= S_IDLE;
              end
              OP_WRITE, OP_READ: begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= (cmd_q.op == OP_WRITE);
                bus.mem_addr <= addr;
                if (cmd_q.op == OP_WRITE) bus.mem_wdata <= cmd_q.payload;
                tmo   <= '0;
                state <= S_ACCESS;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) bus.mon_dreg <= bus.mem_rdata;
            acc_ok <= 1'b1;
            state  <= S_DONE;
          end else if (tmo_hit) begin
            bus.mem_req <= 1'b0;
            acc_ok      <= 1'b0;
            state       <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          // Aborted accesses keep the address so the host can retry in place.
          if (acc_ok && cmd_q.inc) addr <= addr + 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mon_ready <= 1'b1;
      bus.mon_error <= 1'b0;
    end else begin
      bus.mon_ready <= (state == S_IDLE) && empty && !push;
      if (tmo_hit || par_err) bus.mon_error <= 1'b1;
      else if (bus.err_clr)   bus.mon_error <= 1'b0;
    end
  end

endmodule

// File: doc/nios_debug_cmd_sequencer.md
Name: nios_debug_cmd_sequencer

Overview:
Sysclk-side controller that sequences debug-host commands onto the on-chip debug memory (OCI RAM/register file) of the Nios debug module.
- Accepts 38-bit command words (jdo format) already synchronized into the clk domain.
- Buffers them in a small FIFO, then executes them one at a time as single-word memory transactions with an auto-incrementing address.
- Returns read data and status as mon_dreg, mon_ready and mon_error, which feed the debug slave's MonDReg, monitor_ready and monitor_error capture.

Parameters:
ADDR_W, 8, width of memory word address.
CMD_DEPTH, 4, command FIFO depth (power of two, minimum 2).
TIMEOUT_CYCLES, 64, maximum cycles to wait for mem_ack before aborting (minimum 2).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command word present.
cmd_ready  out  1  FIFO can accept; transfer when cmd_valid & cmd_ready.
cmd_data  in  38  [37:36] op, [35] auto-increment, [34] parity (feature), [31:0] payload.
mem_req  out  1  memory request, held until ack or timeout.
mem_we  out  1  1 = write, 0 = read; stable while mem_req.
mem_addr  out  ADDR_W  word address; stable while mem_req.
mem_wdata  out  32  write data; stable while mem_req.
mem_ack  in  1  one-cycle completion strobe; ignored when mem_req = 0.
mem_rdata  in  32  read data, valid with mem_ack.
mon_dreg  out  32  last read data.
mon_ready  out  1  1 when FIFO empty and FSM in IDLE.
mon_error  out  1  sticky error flag.
err_clr  in  1  clears mon_error.

Behaviour:
Reset values:
- FIFO empty; cmd_ready = 1.
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- mon_dreg = 0, mon_ready = 1, mon_error = 0.
- addr register = 0; FSM in IDLE.

FIFO:
- Standard synchronous FIFO. cmd_ready = !full.
- Simultaneous push and pop while full is not permitted; cmd_ready is low, so no push occurs.
- Push and pop in the same cycle when neither full nor empty: occupancy unchanged.

Ops:
- 00 NOP: no effect.
- 01 SETADDR: addr <= payload[ADDR_W-1:0]. One cycle, no memory access.
- 10 WRITE: mem_wdata <= payload.
- 11 READ: read from the current address.
- WRITE and READ use the address held before the command. If [35] = 1, addr increments by 1 on completion and wraps modulo 2^ADDR_W (0xFF+1 -> 0x00 at the default width).

FSM states: IDLE, DECODE, ACCESS, DONE.
- IDLE -> DECODE: FIFO not empty. Pop the head into the cmd register.
- DECODE -> IDLE: for NOP and SETADDR (addr updated this cycle).
- DECODE -> ACCESS: for WRITE/READ. Assert mem_req next cycle and load the timeout counter to 0.
- ACCESS, on mem_ack: deassert mem_req next cycle. For READ, capture mon_dreg <= mem_rdata. Go to DONE.
- ACCESS, on timeout (counter reaches TIMEOUT_CYCLES-1 without ack): deassert mem_req, set mon_error, leave addr unchanged, go to DONE. A late ack after abort is ignored.
- DONE -> IDLE: apply auto-increment (successful access only).

Latency:
- SETADDR: 2 cycles from pop.
- WRITE/READ with ack in the first ACCESS cycle: 4 cycles from pop to the next IDLE.

mon_ready:
- Registered. Goes low the cycle after a push into an empty idle block.
- Goes high the cycle after the FSM returns to IDLE with the FIFO empty.

mon_error:
- Set on timeout or parity error.
- err_clr clears it. If set and clear coincide in the same cycle, set wins.

Reset mid-operation: asynchronous assertion immediately drops mem_req, empties the FIFO and returns all outputs to their reset values. An in-flight command is lost.

Optional Feature:
Macro NIOS_DEBUG_CMD_PARITY_EN.
- Defined: in DECODE, odd parity is checked over cmd_data[37:0] (bit 34 included). If parity is even, the command is discarded, mon_error is set, the FSM goes to IDLE, and no memory access or address change occurs.
- Undefined: bit 34 is ignored and no parity logic is synthesized.

Test Plan:
1. Reset, then push SETADDR 0x10, then WRITE 0xDEADBEEF with auto-increment -> one mem_req with we = 1, addr 0x10, wdata 0xDEADBEEF; addr becomes 0x11; mon_ready returns to 1.
2. SETADDR 0x10, READ with auto-increment, memory returns 0x12345678 after 3 cycles -> mem_req held 3 cycles, mon_dreg = 0x12345678, addr = 0x11.
3. Push 5 commands back-to-back with CMD_DEPTH = 4 and mem_ack held off -> cmd_ready drops after the 4th FIFO entry. The 5th is accepted after the first pop; all 5 execute in order.
4. SETADDR 0xFF, WRITE with auto-increment -> addr wraps to 0x00; the next READ without auto-increment targets 0x00.
5. READ with mem_ack never asserted -> mem_req drops after exactly 64 cycles, mon_error = 1, addr unchanged. A late ack is ignored. err_clr clears mon_error; set and clear in the same cycle keeps mon_error = 1.
6. Assert reset_n low mid-ACCESS with 2 commands queued -> mem_req = 0 immediately, FIFO empty, mon_ready = 1. With NIOS_DEBUG_CMD_PARITY_EN defined, an even-parity WRITE produces no mem_req and sets mon_error.
